datapath_unit: RTL and testbench

Execute/memory responder for the control unit. It accepts one decoded operation (operands, offset, opcode, select and write strobes) per `issue` strobe, then runs the ALU and, when required, the 32-entry data memory. It returns the write-back value on `result2` with a one-cycle `done` pulse, so the control unit's register file can capture it.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/datapath_unit_if.sv | 41 ++++
 rtl/datapath_alu.sv | 58 +++++
 rtl/datapath_unit.sv | 150 +++++++++++++++
 tb/tb_datapath_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the datapath: default widths, ALU opcodes and FSM state encoding.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_BITS_DEF  = 5;

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpNot   = 4'b0101;
  localparam logic [3:0] OpShl   = 4'b0110;
  localparam logic [3:0] OpShr   = 4'b0111;
  localparam logic [3:0] OpInc   = 4'b1000;
  localparam logic [3:0] OpDec   = 4'b1001;
  localparam logic [3:0] OpPassA = 4'b1010;
  localparam logic [3:0] OpPassB = 4'b1011;
  localparam logic [3:0] OpNop   = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StMem  = 2'd2,
    StResp = 2'd3
  } state_e;

  // A store always touches memory, even if sel1 also asks for the ALU result.
  function automatic logic is_mem_op(logic sel1, logic w_r);
    return w_r || !sel1;
  endfunction

endpackage

// File: rtl/datapath_unit_if.sv
// Request/response bundle between the control unit and datapath_unit.
// DATAPATH_FLAGS_EN adds the registered zero/carry flags output.
interface datapath_unit_if #(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH_DEF
);

  logic                  issue;
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] offset;
  logic [3:0]            opcode;
  logic                  sel1;
  logic                  sel3;
  logic                  w_r;
  logic [DATA_WIDTH-1:0] result2;
  logic                  done;
  logic                  busy;

`ifdef DATAPATH_FLAGS_EN
  logic [1:0]            flags;

  modport master (
    output issue, operand1, operand2, offset, opcode, sel1, sel3, w_r,
    input  result2, done, busy, flags
  );
  modport slave (
    input  issue, operand1, operand2, offset, opcode, sel1, sel3, w_r,
    output result2, done, busy, flags
  );
`else
  modport master (
    output issue, operand1, operand2, offset, opcode, sel1, sel3, w_r,
    input  result2, done, busy
  );
  modport slave (
    input  issue, operand1, operand2, offset, opcode, sel1, sel3, w_r,
    output result2, done, busy
  );
`endif

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: result modulo 2^DATA_WIDTH plus carry (ADD/INC) or borrow (SUB/DEC).
module datapath_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [3:0]            opcode_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o
);

  logic [DATA_WIDTH:0] wide;
  logic [2:0]          shamt;

  assign shamt = b_i[2:0];

  always_comb begin
    wide     = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (opcode_i)
      OpAdd: begin
        wide     = {1'b0, a_i} + {1'b0, b_i};
        result_o = wide[DATA_WIDTH-1:0];
        carry_o  = wide[DATA_WIDTH];
      end
      // Extra top bit becomes the borrow when the subtraction underflows.
      OpSub: begin
        wide     = {1'b0, a_i} - {1'b0, b_i};
        result_o = wide[DATA_WIDTH-1:0];
        carry_o  = wide[DATA_WIDTH];
      end
      OpAnd:   result_o = a_i & b_i;
      OpOr:    result_o = a_i | b_i;
      OpXor:   result_o = a_i ^ b_i;
      OpNot:   result_o = ~a_i;
      OpShl:   result_o = a_i << shamt;
      OpShr:   result_o = a_i >> shamt;
      OpInc: begin
        wide     = {1'b0, a_i} + (DATA_WIDTH + 1)'(1);
        result_o = wide[DATA_WIDTH-1:0];
        carry_o  = wide[DATA_WIDTH];
      end
      OpDec: begin
        wide     = {1'b0, a_i} - (DATA_WIDTH + 1)'(1);
        result_o = wide[DATA_WIDTH-1:0];
        carry_o  = wide[DATA_WIDTH];
      end
      OpPassA: result_o = a_i;
      OpPassB: result_o = b_i;
      OpNop:   result_o = '0;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/datapath_unit.sv
// Execute/memory responder: IDLE -> EXEC -> (MEM) -> RESP, returning result2 with a done pulse.
// Optional DATAPATH_FLAGS_EN adds registered zero/carry flags.
module datapath_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF
) (
  input logic            clk,
  input logic            rst,
  datapath_unit_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] op1_q, op2_q, off_q;
  logic [3:0]            opcode_q;
  logic                  sel1_q, sel3_q, wr_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] result2_q, result2_d;
  logic                  result_load;

  logic [DATA_WIDTH-1:0] alu_b, alu_res;
  logic                  alu_carry;
  logic                  mem_op;
  logic [ADDR_BITS-1:0]  addr;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  assign alu_b  = sel3_q ? off_q : op2_q;
  assign mem_op = is_mem_op(sel1_q, wr_q);
  assign addr   = alu_q[ADDR_BITS-1:0];

  datapath_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .opcode_i(opcode_q),
    .a_i     (op1_q),
    .b_i     (alu_b),
    .result_o(alu_res),
    .carry_o (alu_carry)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.issue) state_d = StExec;
      StExec:  state_d = mem_op ? StMem : StResp;
      StMem:   state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StResp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      off_q    <= '0;
      opcode_q <= '0;
      sel1_q   <= 1'b0;
      sel3_q   <= 1'b0;
      wr_q     <= 1'b0;
      alu_q    <= '0;
    end else begin
      if (state_q == StIdle && bus.issue) begin
        op1_q    <= bus.operand1;
        op2_q    <= bus.operand2;
        off_q    <= bus.offset;
        opcode_q <= bus.opcode;
        sel1_q   <= bus.sel1;
        sel3_q   <= bus.sel3;
        wr_q     <= bus.w_r;
      end
      if (state_q == StExec) alu_q <= alu_res;
    end
  end

  // result2 is loaded on entry to RESP so it is valid alongside done.
  always_comb begin
    result2_d   = result2_q;
    result_load = 1'b0;
    if (state_q == StExec && !mem_op) begin
      result2_d   = alu_res;
      result_load = 1'b1;
    end else if (state_q == StMem) begin
      result2_d   = wr_q ? op2_q : mem_q[addr];
      result_load = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result2_q <= '0;
    end else if (result_load) begin
      result2_q <= result2_d;
    end
  end

  assign bus.result2 = result2_q;

  // No reset on storage; the write is gated by state, which reset clears asynchronously.
  always_ff @(posedge clk) begin
    if (state_q == StMem && wr_q) mem_q[addr] <= op2_q;
  end

`ifdef DATAPATH_FLAGS_EN
  logic [1:0] flags_q, flags_d;

  always_comb begin
    flags_d[0] = (result2_d == '0);
    flags_d[1] = (state_q == StExec) ? alu_carry : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (result_load) begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags = flags_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  logic unused_alu_hi;
  assign unused_alu_hi = ^alu_q[DATA_WIDTH-1:ADDR_BITS];

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboard bench for datapath_unit: driver pushes reference-model expectations, monitor pops on done.
module tb_datapath_unit;
  import cpu_pkg::*;

  localparam int DW    = 8;
  localparam int MOD   = 256;
  localparam int DEPTH = 32;

  typedef struct {
    int res;
    int flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datapath_unit_if #(.DATA_WIDTH(DW)) ifc ();

  datapath_unit #(
    .DATA_WIDTH(DW),
    .ADDR_BITS (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  exp_t exp_q[$];
  int   mem_m[DEPTH];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int ref_alu(input int opc, input int a, input int b, output int c);
    int r;
    c = 0;
    case (opc)
      0:  begin r = a + b; c = (r >= MOD) ? 1 : 0; end
      1:  begin r = a - b; c = (a < b) ? 1 : 0; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = MOD - 1 - a;
      6:  r = a * (1 << (b % 8));
      7:  r = a / (1 << (b % 8));
      8:  begin r = a + 1; c = (a == MOD - 1) ? 1 : 0; end
      9:  begin r = a - 1; c = (a == 0) ? 1 : 0; end
      10: r = a;
      11: r = b;
      default: r = 0;
    endcase
    if (r < 0) r += MOD;
    return r % MOD;
  endfunction

  function automatic exp_t model(input int a, input int b, input int o, input int opc,
                                 input bit s1, input bit s3, input bit w);
    exp_t e;
    int   c, alu, addr;
    alu  = ref_alu(opc, a, s3 ? o : b, c);
    addr = alu % DEPTH;
    if (w) begin
      mem_m[addr] = b;
      e.res = b;
      e.flg = (b == 0) ? 1 : 0;
    end else if (!s1) begin
      e.res = mem_m[addr];
      e.flg = (e.res == 0) ? 1 : 0;
    end else begin
      e.res = alu;
      e.flg = ((alu == 0) ? 1 : 0) + 2 * c;
    end
    return e;
  endfunction

  task automatic drive(input int a, input int b, input int o, input logic [3:0] opc,
                       input bit s1, input bit s3, input bit w);
    ifc.operand1 = 8'(a);
    ifc.operand2 = 8'(b);
    ifc.offset   = 8'(o);
    ifc.opcode   = opc;
    ifc.sel1     = s1;
    ifc.sel3     = s3;
    ifc.w_r      = w;
    ifc.issue    = 1'b1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (ifc.busy && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 20) chk("idle_timeout", 32'(ifc.busy), 0);
  endtask

  task automatic run_op(input int a, input int b, input int o, input logic [3:0] opc,
                        input bit s1, input bit s3, input bit w);
    int lat = 0;
    int want;
    wait_idle();
    drive(a, b, o, opc, s1, s3, w);
    exp_q.push_back(model(a, b, o, int'(opc), s1, s3, w));
    @(posedge clk);
    #1;
    ifc.issue = 1'b0;
    want = (w || !s1) ? 2 : 1;
    while (!ifc.done && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, want);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifc.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(ifc.done), 0);
        end else begin
          e = exp_q.pop_front();
          chk("result2", 32'(ifc.result2), e.res);
`ifdef DATAPATH_FLAGS_EN
          chk("flags", 32'(ifc.flags), e.flg);
`endif
        end
      end
    end
  end

  initial begin : stim
    int v, k;
    ifc.issue = 1'b0; ifc.operand1 = '0; ifc.operand2 = '0; ifc.offset = '0;
    ifc.opcode = '0; ifc.sel1 = 1'b0; ifc.sel3 = 1'b0; ifc.w_r = 1'b0;
    #1;
    chk("rst_result2", 32'(ifc.result2), 0);
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
`ifdef DATAPATH_FLAGS_EN
    chk("rst_flags", 32'(ifc.flags), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(5, 3, 0, OpAdd, 1, 0, 0);
    chk("add_direct", 32'(ifc.result2), 8);

    // Fill every address so later random loads have defined data.
    for (int i = 0; i < DEPTH; i++) run_op(i, (i * 37 + 11) % MOD, 0, OpAdd, 1, 1, 1);

    run_op(2, 8'hAA, 4, OpAdd, 1, 1, 1);
    chk("store_direct", 32'(ifc.result2), 32'hAA);
    run_op(1, 0, 5, OpAdd, 0, 1, 0);
    chk("load_direct", 32'(ifc.result2), 32'hAA);

    run_op(8'h1F, 8'h55, 8'h02, OpAdd, 1, 1, 1);
    run_op(1, 0, 0, OpAdd, 0, 0, 0);
    chk("wrap_load", 32'(ifc.result2), 32'h55);

    run_op(3, 3, 0, OpSub, 1, 0, 0);
`ifdef DATAPATH_FLAGS_EN
    chk("sub_flags", 32'(ifc.flags), 1);
`endif
    run_op(8'hFF, 1, 0, OpAdd, 1, 0, 0);
    chk("add_wrap", 32'(ifc.result2), 0);
`ifdef DATAPATH_FLAGS_EN
    chk("add_flags", 32'(ifc.flags), 3);
`endif

    for (int i = 0; i < 60; i++) begin
      run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
    end

    // Reset during EXEC: outputs clear at once and no done follows.
    run_op(5, 3, 0, OpAdd, 1, 0, 0);
    wait_idle();
    drive(7, 9, 0, OpAdd, 1, 0, 0);
    @(posedge clk);
    #1 ifc.issue = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_result2", 32'(ifc.result2), 0);
    chk("midrst_busy", 32'(ifc.busy), 0);
    chk("midrst_done", 32'(ifc.done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset while in MEM: the store must not commit.
    v = (mem_m[7] + 1) % MOD;
    drive(7, v, 0, OpAdd, 1, 1, 1);
    @(posedge clk);
    #1 ifc.issue = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("memrst_busy", 32'(ifc.busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_op(7, 0, 0, OpAdd, 0, 1, 0);
    chk("memrst_old", 32'(ifc.result2), mem_m[7]);

    // Issue pulsed while busy is dropped.
    wait_idle();
    drive(10, 20, 0, OpAdd, 1, 0, 0);
    exp_q.push_back(model(10, 20, 0, 0, 1, 0, 0));
    @(posedge clk);
    #1 drive(40, 1, 0, OpSub, 1, 0, 0);
    @(posedge clk);
    #1 ifc.issue = 1'b0;
    chk("pulse_done", 32'(ifc.done), 1);
    @(posedge clk);
    #1 chk("pulse_ignored", 32'(ifc.busy), 0);

    // Issue held through done: second op starts on the edge after RESP->IDLE.
    drive(8'h0F, 8'hF0, 0, OpXor, 1, 0, 0);
    exp_q.push_back(model(8'h0F, 8'hF0, 0, int'(OpXor), 1, 0, 0));
    @(posedge clk);
    #1 drive(9, 4, 0, OpSub, 1, 0, 0);
    exp_q.push_back(model(9, 4, 0, int'(OpSub), 1, 0, 0));
    @(posedge clk);
    #1 chk("held_done_a", 32'(ifc.done), 1);
    @(posedge clk);
    #1 chk("held_idle", 32'(ifc.busy), 0);
    @(posedge clk);
    #1 chk("held_accept", 32'(ifc.busy), 1);
    ifc.issue = 1'b0;
    @(posedge clk);
    #1 chk("held_done_b", 32'(ifc.done), 1);

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    chk("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
